// File: rtl/stopwatch_watch_ctrl_pkg.sv
// rtl/stopwatch_watch_ctrl_pkg.sv - shared state and field codes for the stopwatch/watch control
// Purpose: stopwatch and watch FSM state encodings, o_set_field codes consumed by the
//          watch datapath, and the state-to-field mapping.
// Ports:   none (package).
package stopwatch_watch_ctrl_pkg;

  typedef enum logic [1:0] {
    SW_STOP  = 2'd0,
    SW_RUN   = 2'd1,
    SW_CLEAR = 2'd2
  } sw_state_e;

  // Ordered so that a run pulse advances the watch FSM by simple increment,
  // wrapping W_SET_SEC back to W_SHOW.
  typedef enum logic [1:0] {
    W_SHOW     = 2'd0,
    W_SET_HOUR = 2'd1,
    W_SET_MIN  = 2'd2,
    W_SET_SEC  = 2'd3
  } w_state_e;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  function automatic logic [1:0] field_of(input w_state_e s);
    case (s)
      W_SET_HOUR: field_of = FIELD_HOUR;
      W_SET_MIN:  field_of = FIELD_MIN;
      W_SET_SEC:  field_of = FIELD_SEC;
      default:    field_of = FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_watch_ctrl_timer.sv
// rtl/stopwatch_watch_ctrl_timer.sv - idle timeout counter for the watch SET states
// Purpose: counts idle cycles while i_run is high; i_clr zeroes it. Saturates at
//          TIMEOUT_CYC-1 and flags o_expire there.
// Ports:   clk, reset (async, active-high), i_run (in a SET state), i_clr (clear count),
//          o_expire (count reached TIMEOUT_CYC-1 with no clear this cycle).
module set_timeout_timer #(
  parameter int TIMEOUT_CYC = 1_000_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_run && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A button pulse in the same cycle counts as user activity and wins over expiry.
  assign o_expire = i_run && !i_clr && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_watch_ctrl.sv
// rtl/stopwatch_watch_ctrl.sv - central run/stop/clear and time-set control FSM
// Purpose: turns debounced button pulses into stopwatch run/clear, watch field
//          select and inc/dec pulses, and the stopwatch/watch view select.
// Build option: LAP_FREEZE_EN enables the lap display freeze toggled by down.
// Ports:   clk, reset (async, active-high);
//          i_btn_run/clear/mode/up/down: 1-cycle button pulses;
//          o_sw_run (level), o_sw_clear (pulse), o_watch_mode (0 sw, 1 watch),
//          o_set_field (00 none/01 hour/10 min/11 sec), o_inc/o_dec (pulses),
//          o_lap_freeze (level).
module stopwatch_watch_ctrl
  import stopwatch_watch_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  output logic       o_sw_run,
  output logic       o_sw_clear,
  output logic       o_watch_mode,
  output logic [1:0] o_set_field,
  output logic       o_inc,
  output logic       o_dec,
  output logic       o_lap_freeze
);

  sw_state_e  sw_state_d, sw_state_q;
  w_state_e   w_state_d, w_state_q;
  logic       watch_mode_d, watch_mode_q;
  logic       sw_run_d, sw_run_q;
  logic       sw_clear_d, sw_clear_q;
  logic [1:0] set_field_d, set_field_q;
  logic       inc_d, inc_q;
  logic       dec_d, dec_q;
  logic       lap_d, lap_q;

  logic any_pulse, in_set, expire;
  logic clr_act, run_act, ud_ok, up_act, dn_act;

  assign any_pulse = i_btn_run | i_btn_clear | i_btn_mode | i_btn_up | i_btn_down;
  assign in_set    = (w_state_q != W_SHOW);

  // Priority mode > clear > run > up/down; lower pulses in the same cycle are dropped.
  assign clr_act = i_btn_clear & ~i_btn_mode;
  assign run_act = i_btn_run & ~i_btn_mode & ~i_btn_clear;
  assign ud_ok   = ~i_btn_mode & ~i_btn_clear & ~i_btn_run;
  assign up_act  = ud_ok & i_btn_up & ~i_btn_down;
  assign dn_act  = ud_ok & i_btn_down & ~i_btn_up;

  set_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_run    (in_set),
    .i_clr    (any_pulse | ~in_set),
    .o_expire (expire)
  );

  always_comb begin
    sw_state_d   = sw_state_q;
    w_state_d    = w_state_q;
    watch_mode_d = watch_mode_q;
    inc_d        = 1'b0;
    dec_d        = 1'b0;
    lap_d        = lap_q;

    if (i_btn_mode) begin
      watch_mode_d = ~watch_mode_q;
    end

    // The stopwatch keeps its state while the watch is viewed.
    case (sw_state_q)
      SW_STOP: begin
        if (!watch_mode_q && run_act) begin
          sw_state_d = SW_RUN;
        end else if (!watch_mode_q && clr_act) begin
          sw_state_d = SW_CLEAR;
        end
      end
      SW_RUN: begin
        if (!watch_mode_q && run_act) begin
          sw_state_d = SW_STOP;
        end
      end
      default: sw_state_d = SW_STOP;
    endcase

    if (watch_mode_q) begin
      if (in_set && clr_act) begin
        w_state_d = W_SHOW;
      end else if (run_act) begin
        w_state_d = w_state_e'(w_state_q + 2'd1);
      end else if (expire) begin
        w_state_d = W_SHOW;
      end
      if (in_set) begin
        inc_d = up_act;
        dec_d = dn_act;
      end
      if (i_btn_mode) begin
        w_state_d = W_SHOW;
      end
    end

`ifdef LAP_FREEZE_EN
    if (!watch_mode_q && (sw_state_q == SW_RUN) && dn_act) begin
      lap_d = ~lap_q;
    end
    if (sw_state_d == SW_CLEAR) begin
      lap_d = 1'b0;
    end
`else
    lap_d = 1'b0;
`endif

    sw_run_d    = (sw_state_d == SW_RUN);
    sw_clear_d  = (sw_state_d == SW_CLEAR);
    set_field_d = field_of(w_state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_state_q   <= SW_STOP;
      w_state_q    <= W_SHOW;
      watch_mode_q <= 1'b0;
      sw_run_q     <= 1'b0;
      sw_clear_q   <= 1'b0;
      set_field_q  <= FIELD_NONE;
      inc_q        <= 1'b0;
      dec_q        <= 1'b0;
      lap_q        <= 1'b0;
    end else begin
      sw_state_q   <= sw_state_d;
      w_state_q    <= w_state_d;
      watch_mode_q <= watch_mode_d;
      sw_run_q     <= sw_run_d;
      sw_clear_q   <= sw_clear_d;
      set_field_q  <= set_field_d;
      inc_q        <= inc_d;
      dec_q        <= dec_d;
      lap_q        <= lap_d;
    end
  end

  assign o_sw_run     = sw_run_q;
  assign o_sw_clear   = sw_clear_q;
  assign o_watch_mode = watch_mode_q;
  assign o_set_field  = set_field_q;
  assign o_inc        = inc_q;
  assign o_dec        = dec_q;
  assign o_lap_freeze = lap_q;

endmodule

// File: tb/tb_stopwatch_watch_ctrl.sv
// tb/tb_stopwatch_watch_ctrl.sv - directed scoreboard bench for stopwatch_watch_ctrl
module tb_stopwatch_watch_ctrl;

  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] M = 5'b10000;
  localparam logic [4:0] C = 5'b01000;
  localparam logic [4:0] R = 5'b00100;
  localparam logic [4:0] U = 5'b00010;
  localparam logic [4:0] D = 5'b00001;

`ifdef LAP_FREEZE_EN
  localparam logic LAP = 1'b1;
`else
  localparam logic LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       i_btn_run, i_btn_clear, i_btn_mode, i_btn_up, i_btn_down;
  logic       o_sw_run, o_sw_clear, o_watch_mode, o_inc, o_dec, o_lap_freeze;
  logic [1:0] o_set_field;

  logic [7:0] sb[$];
  int vectors = 0;
  int miscompares = 0;

  stopwatch_watch_ctrl #(.TIMEOUT_CYC(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_btn_run    (i_btn_run),
    .i_btn_clear  (i_btn_clear),
    .i_btn_mode   (i_btn_mode),
    .i_btn_up     (i_btn_up),
    .i_btn_down   (i_btn_down),
    .o_sw_run     (o_sw_run),
    .o_sw_clear   (o_sw_clear),
    .o_watch_mode (o_watch_mode),
    .o_set_field  (o_set_field),
    .o_inc        (o_inc),
    .o_dec        (o_dec),
    .o_lap_freeze (o_lap_freeze)
  );

  always #5 clk = ~clk;

  // {sw_run, sw_clear, watch_mode, set_field, inc, dec, lap_freeze}
  function automatic logic [7:0] ev(input logic r, input logic c, input logic w,
                                    input logic [1:0] f, input logic i, input logic d,
                                    input logic l);
    return {r, c, w, f, i, d, l};
  endfunction

  task automatic compare(input string tag);
    logic [7:0] obs;
    logic [7:0] want;
    obs  = {o_sw_run, o_sw_clear, o_watch_mode, o_set_field, o_inc, o_dec, o_lap_freeze};
    want = sb.pop_front();
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (run,clr,wm,field,inc,dec,lap)", tag, obs, want);
    end
  endtask

  task automatic check_now(input string tag, input logic [7:0] want);
    sb.push_back(want);
    compare(tag);
  endtask

  task automatic step(input string tag, input logic [4:0] btn, input logic [7:0] want);
    {i_btn_mode, i_btn_clear, i_btn_run, i_btn_up, i_btn_down} = btn;
    sb.push_back(want);
    @(posedge clk);
    #1;
    {i_btn_mode, i_btn_clear, i_btn_run, i_btn_up, i_btn_down} = N;
    compare(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    {i_btn_mode, i_btn_clear, i_btn_run, i_btn_up, i_btn_down} = N;
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_state", ev(0,0,0,2'b00,0,0,0));
    reset = 1'b0;

    // reset in the middle of a run
    step("t1_run", R, ev(1,0,0,2'b00,0,0,0));
    for (int k = 0; k < 5; k++) step("t1_hold", N, ev(1,0,0,2'b00,0,0,0));
    #3;
    reset = 1'b1;
    #1;
    check_now("t1_async_reset", ev(0,0,0,2'b00,0,0,0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("t1_after_reset", N, ev(0,0,0,2'b00,0,0,0));

    // stopwatch run/stop/clear
    step("t2_run", R, ev(1,0,0,2'b00,0,0,0));
    step("t2_stop", R, ev(0,0,0,2'b00,0,0,0));
    step("t2_clear", C, ev(0,1,0,2'b00,0,0,0));
    step("t2_clear_end", N, ev(0,0,0,2'b00,0,0,0));
    step("t2_run2", R, ev(1,0,0,2'b00,0,0,0));
    step("t2_clear_in_run", C, ev(1,0,0,2'b00,0,0,0));
    step("t2_run_hold", N, ev(1,0,0,2'b00,0,0,0));
    step("t2_stop2", R, ev(0,0,0,2'b00,0,0,0));

    // watch time set
    step("t3_mode", M, ev(0,0,1,2'b00,0,0,0));
    step("t3_set_hour", R, ev(0,0,1,2'b01,0,0,0));
    step("t3_up1", U, ev(0,0,1,2'b01,1,0,0));
    step("t3_up1_end", N, ev(0,0,1,2'b01,0,0,0));
    step("t3_up2", U, ev(0,0,1,2'b01,1,0,0));
    step("t3_up2_end", N, ev(0,0,1,2'b01,0,0,0));
    step("t3_down", D, ev(0,0,1,2'b01,0,1,0));
    step("t3_down_end", N, ev(0,0,1,2'b01,0,0,0));
    step("t3_set_min", R, ev(0,0,1,2'b10,0,0,0));
    step("t3_set_sec", R, ev(0,0,1,2'b11,0,0,0));
    step("t3_show", R, ev(0,0,1,2'b00,0,0,0));
    step("t3_up_in_show", U, ev(0,0,1,2'b00,0,0,0));
    step("t3_set_hour2", R, ev(0,0,1,2'b01,0,0,0));
    step("t3_abort", C, ev(0,0,1,2'b00,0,0,0));

    // coincident pulses
    step("t4_to_sw", M, ev(0,0,0,2'b00,0,0,0));
    step("t4_run", R, ev(1,0,0,2'b00,0,0,0));
    step("t4_mode_run_a", M | R, ev(1,0,1,2'b00,0,0,0));
    step("t4_mode_run_b", M | R, ev(1,0,0,2'b00,0,0,0));
    step("t4_stop", R, ev(0,0,0,2'b00,0,0,0));
    step("t4_to_watch", M, ev(0,0,1,2'b00,0,0,0));
    step("t4_set_hour", R, ev(0,0,1,2'b01,0,0,0));
    step("t4_up_down", U | D, ev(0,0,1,2'b01,0,0,0));
    step("t4_leave_watch", M, ev(0,0,0,2'b00,0,0,0));
    step("t4_clear_run", C | R, ev(0,1,0,2'b00,0,0,0));
    step("t4_clear_end", N, ev(0,0,0,2'b00,0,0,0));
    step("t4_back_watch", M, ev(0,0,1,2'b00,0,0,0));

    // idle timeout in W_SET_MIN
    step("t5_set_hour", R, ev(0,0,1,2'b01,0,0,0));
    step("t5_set_min", R, ev(0,0,1,2'b10,0,0,0));
    for (int k = 0; k < 19; k++) step("t5_idle", N, ev(0,0,1,2'b10,0,0,0));
    step("t5_timeout", N, ev(0,0,1,2'b00,0,0,0));
    step("t5b_set_hour", R, ev(0,0,1,2'b01,0,0,0));
    step("t5b_set_min", R, ev(0,0,1,2'b10,0,0,0));
    for (int k = 0; k < 9; k++) step("t5b_idle", N, ev(0,0,1,2'b10,0,0,0));
    step("t5b_up_restart", U, ev(0,0,1,2'b10,1,0,0));
    for (int k = 0; k < 19; k++) step("t5b_idle2", N, ev(0,0,1,2'b10,0,0,0));
    step("t5b_timeout", N, ev(0,0,1,2'b00,0,0,0));

    // lap freeze (tied low in the default build)
    step("t6_to_sw", M, ev(0,0,0,2'b00,0,0,0));
    step("t6_run", R, ev(1,0,0,2'b00,0,0,0));
    step("t6_down1", D, ev(1,0,0,2'b00,0,0,LAP));
    step("t6_down2", D, ev(1,0,0,2'b00,0,0,0));
    step("t6_down3", D, ev(1,0,0,2'b00,0,0,LAP));
    step("t6_stop", R, ev(0,0,0,2'b00,0,0,LAP));
    step("t6_clear", C, ev(0,1,0,2'b00,0,0,0));
    step("t6_clear_end", N, ev(0,0,0,2'b00,0,0,0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
